// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_detect_pkg;

    typedef enum logic [0:0] {
        Fill,
        Armed
    } state_e;

    // Power-on configuration: pattern 10010, length 5, overlapping matches.
    localparam logic [31:0] DEF_PAT = 32'h0000_0012;
    localparam int unsigned DEF_LEN = 5;
    localparam bit          DEF_OVL = 1'b1;

    // A zero length would never compare, so it is promoted to 1.
    // Over-long requests are capped at the history depth.
    function automatic int unsigned clamp_len(int unsigned len, int unsigned max_len);
        if (len == 0) begin
            return 1;
        end else if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

    // Mask with the low len bits set.
    function automatic logic [31:0] len_mask(int unsigned len);
        if (len >= 32) begin
            return '1;
        end else begin
            return (32'd1 << len) - 32'd1;
        end
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky saturation flag and a clear that
// takes priority over a simultaneous increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         sat_q, sat_d;

    // Next count: hold at all-ones; the flag sets once the top is reached.
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else begin
            if (inc && (cnt_q != '1)) begin
                cnt_d = cnt_q + W'(1);
            end
            sat_d = sat_q | (&cnt_d);
        end
    end

    // Counter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = sat_q;

endmodule

// File: rtl/seq_detect_param.sv
// Run-time configurable serial bit-pattern detector. Valid-qualified input
// bits shift into a history register; once len bits have been collected each
// beat compares the newest len bits against the pattern.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned          PAT_W   = 8,
    parameter int unsigned          CNT_W   = 8,
    parameter logic [PAT_W-1:0]     RST_PAT = PAT_W'(DEF_PAT),
    parameter int unsigned          RST_LEN = DEF_LEN,
    parameter bit                   RST_OVL = DEF_OVL
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         din_valid,
    input  logic                         din,
    input  logic                         cfg_we,
    input  logic [PAT_W-1:0]             cfg_pat,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    input  logic                         cfg_ovl,
    input  logic                         clr_cnt,
    output logic                         match,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         cnt_sat,
    output logic                         armed
);

    localparam int unsigned LenW = $clog2(PAT_W + 1);
    localparam logic [LenW-1:0] RstLen = LenW'(clamp_len(RST_LEN, PAT_W));

    state_e           state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d, pat_q, pat_d;
    logic [LenW-1:0]  fill_q, fill_d, len_q, len_d;
    logic             ovl_q, ovl_d, match_q, match_d;
    logic [PAT_W-1:0] hist_new, mask;
    logic [LenW-1:0]  fill_inc;
    logic             hit;

    assign hist_new = {hist_q[PAT_W-2:0], din};
    assign mask     = PAT_W'(len_mask(32'(len_q)));
    assign fill_inc = (fill_q < len_q) ? fill_q + LenW'(1) : fill_q;

    // Next-state: config load beats data; a hit may restart filling.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        match_d = 1'b0;
        hit     = 1'b0;
        if (cfg_we) begin
            pat_d   = cfg_pat;
            len_d   = LenW'(clamp_len(32'(cfg_len), PAT_W));
            ovl_d   = cfg_ovl;
            hist_d  = '0;
            fill_d  = '0;
            state_d = Fill;
        end else if (din_valid) begin
            hist_d = hist_new;
            fill_d = fill_inc;
            // Compare on every beat once armed, and on the beat that arms.
            if ((state_q == Armed) || (fill_inc == len_q)) begin
                state_d = Armed;
                hit     = ((hist_new & mask) == (pat_q & mask));
            end
            if (hit) begin
                match_d = 1'b1;
                if (!ovl_q) begin
                    state_d = Fill;
                    fill_d  = '0;
                end
            end
        end
    end

    // Detector state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= Fill;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= RST_PAT;
            len_q   <= RstLen;
            ovl_q   <= RST_OVL;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            match_q <= match_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (hit),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

    assign match = match_q;
    assign armed = (state_q == Armed);

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param. A second instance with a 2-bit
// counter shares the inputs and is only examined in the saturation test.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din_valid = 1'b0;
    logic       din = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_pat = 8'h12;
    logic [3:0] cfg_len = 4'd5;
    logic       cfg_ovl = 1'b1;
    logic       clr_cnt = 1'b0;

    logic       match, cnt_sat, armed;
    logic [7:0] match_cnt;
    logic       match2, cnt_sat2, armed2;
    logic [1:0] match_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_detect_param #(
        .PAT_W (8),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .cfg_we    (cfg_we),
        .cfg_pat   (cfg_pat),
        .cfg_len   (cfg_len),
        .cfg_ovl   (cfg_ovl),
        .clr_cnt   (clr_cnt),
        .match     (match),
        .match_cnt (match_cnt),
        .cnt_sat   (cnt_sat),
        .armed     (armed)
    );

    seq_detect_param #(
        .PAT_W (8),
        .CNT_W (2)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .cfg_we    (cfg_we),
        .cfg_pat   (cfg_pat),
        .cfg_len   (cfg_len),
        .cfg_ovl   (cfg_ovl),
        .clr_cnt   (clr_cnt),
        .match     (match2),
        .match_cnt (match_cnt2),
        .cnt_sat   (cnt_sat2),
        .armed     (armed2)
    );

    // One valid beat; outputs are readable on return (1 time unit after the edge).
    task automatic beat(input logic b);
        din_valid = 1'b1;
        din       = b;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic o,
                             input logic clr);
        cfg_pat = p;
        cfg_len = l;
        cfg_ovl = o;
        cfg_we  = 1'b1;
        clr_cnt = clr;
        @(posedge clk);
        #1;
        cfg_we  = 1'b0;
        clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (match !== 1'b0) begin n_fail++; $display("FAIL reset_match got %b exp 0", match); end
        n_tests++;
        if (match_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_cnt got %0d exp 0", match_cnt);
        end
        n_tests++;
        if (cnt_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %b exp 0", cnt_sat); end
        n_tests++;
        if (armed !== 1'b0) begin n_fail++; $display("FAIL reset_armed got %b exp 0", armed); end
    endtask

    // Default pattern 10010, overlap on: hits after beats 5 and 8.
    task automatic test_overlap();
        logic [7:0] stim = 8'b1001_0010;
        logic [7:0] exp  = 8'b0000_1001;
        for (int i = 7; i >= 0; i--) begin
            beat(stim[i]);
            n_tests++;
            if (match !== exp[i]) begin
                n_fail++; $display("FAIL ovl_match beat %0d got %b exp %b", 8 - i, match, exp[i]);
            end
            if (i == 3) begin
                n_tests++;
                if (armed !== 1'b1) begin n_fail++; $display("FAIL ovl_armed got %b exp 1", armed); end
            end
        end
        n_tests++;
        if (match_cnt !== 8'd2) begin
            n_fail++; $display("FAIL ovl_cnt got %0d exp 2", match_cnt);
        end
    endtask

    // Non-overlap: only the hit at beat 5; armed stays low while refilling.
    task automatic test_nonoverlap();
        logic [7:0] stim = 8'b1001_0010;
        logic [7:0] exp  = 8'b0000_1000;
        configure(8'h12, 4'd5, 1'b0, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            beat(stim[i]);
            n_tests++;
            if (match !== exp[i]) begin
                n_fail++; $display("FAIL novl_match beat %0d got %b exp %b", 8 - i, match, exp[i]);
            end
            if (i <= 3) begin
                n_tests++;
                if (armed !== 1'b0) begin
                    n_fail++; $display("FAIL novl_armed beat %0d got %b exp 0", 8 - i, armed);
                end
            end
        end
        n_tests++;
        if (match_cnt !== 8'd1) begin
            n_fail++; $display("FAIL novl_cnt got %0d exp 1", match_cnt);
        end
    endtask

    // Bubbles between beats must not disturb the match positions.
    task automatic test_bubbles();
        logic [7:0] stim = 8'b1001_0010;
        logic [7:0] exp  = 8'b0000_1001;
        int gap;
        configure(8'h12, 4'd5, 1'b1, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            beat(stim[i]);
            n_tests++;
            if (match !== exp[i]) begin
                n_fail++; $display("FAIL bub_match beat %0d got %b exp %b", 8 - i, match, exp[i]);
            end
            gap = (i % 3) + 1;
            for (int g = 0; g < gap; g++) begin
                idle();
                n_tests++;
                if (match !== 1'b0) begin
                    n_fail++; $display("FAIL bub_idle beat %0d got %b exp 0", 8 - i, match);
                end
            end
        end
        n_tests++;
        if (match_cnt !== 8'd2) begin
            n_fail++; $display("FAIL bub_cnt got %0d exp 2", match_cnt);
        end
    endtask

    // Short patterns, length clamping at both ends.
    task automatic test_lengths();
        logic [4:0] stim3 = 5'b10101;
        logic [4:0] exp3  = 5'b00101;
        logic [7:0] stim8 = 8'hA5;
        logic [7:0] exp8  = 8'b0000_0001;
        configure(8'h05, 4'd3, 1'b1, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            beat(stim3[i]);
            n_tests++;
            if (match !== exp3[i]) begin
                n_fail++; $display("FAIL len3_match beat %0d got %b exp %b", 5 - i, match, exp3[i]);
            end
        end
        // Length 0 loads as 1: every 1 bit is a hit, back to back.
        configure(8'h01, 4'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 2; k++) begin
            beat(1'b1);
            n_tests++;
            if (match !== 1'b1) begin
                n_fail++; $display("FAIL len0_match beat %0d got %b exp 1", k, match);
            end
        end
        // Length 15 loads as 8: one hit once all 8 bits are in.
        configure(8'hA5, 4'd15, 1'b1, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            beat(stim8[i]);
            n_tests++;
            if (match !== exp8[i]) begin
                n_fail++; $display("FAIL len15_match beat %0d got %b exp %b", 8 - i, match, exp8[i]);
            end
        end
    endtask

    // 2-bit counter saturates at 3; clear beats a coincident hit.
    task automatic test_saturate();
        configure(8'h01, 4'd1, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) beat(1'b1);
        n_tests++;
        if (match_cnt2 !== 2'd3) begin
            n_fail++; $display("FAIL sat_cnt2 got %0d exp 3", match_cnt2);
        end
        n_tests++;
        if (cnt_sat2 !== 1'b1) begin n_fail++; $display("FAIL sat_flag2 got %b exp 1", cnt_sat2); end
        n_tests++;
        if (match_cnt !== 8'd5) begin
            n_fail++; $display("FAIL sat_cnt8 got %0d exp 5", match_cnt);
        end
        n_tests++;
        if (cnt_sat !== 1'b0) begin n_fail++; $display("FAIL sat_flag8 got %b exp 0", cnt_sat); end
        clr_cnt = 1'b1;
        beat(1'b1);
        clr_cnt = 1'b0;
        n_tests++;
        if (match2 !== 1'b1) begin n_fail++; $display("FAIL clrhit_match got %b exp 1", match2); end
        n_tests++;
        if (match_cnt2 !== 2'd0) begin
            n_fail++; $display("FAIL clrhit_cnt got %0d exp 0", match_cnt2);
        end
        n_tests++;
        if (cnt_sat2 !== 1'b0) begin
            n_fail++; $display("FAIL clrhit_sat got %b exp 0", cnt_sat2);
        end
    endtask

    // Reset mid-sequence and a config load on the completing beat both kill the match.
    task automatic test_interrupt();
        logic [3:0] pre = 4'b1001;
        logic [4:0] full = 5'b10010;
        do_reset();
        for (int i = 3; i >= 0; i--) beat(pre[i]);
        do_reset();
        beat(1'b0);
        n_tests++;
        if (match !== 1'b0) begin n_fail++; $display("FAIL rstmid_match got %b exp 0", match); end
        n_tests++;
        if (armed !== 1'b0) begin n_fail++; $display("FAIL rstmid_armed got %b exp 0", armed); end
        n_tests++;
        if (match_cnt !== 8'd0) begin
            n_fail++; $display("FAIL rstmid_cnt got %0d exp 0", match_cnt);
        end
        for (int i = 3; i >= 0; i--) beat(pre[i]);
        cfg_pat   = 8'h12;
        cfg_len   = 4'd5;
        cfg_ovl   = 1'b1;
        cfg_we    = 1'b1;
        din_valid = 1'b1;
        din       = 1'b0;
        @(posedge clk);
        #1;
        cfg_we    = 1'b0;
        din_valid = 1'b0;
        n_tests++;
        if (match !== 1'b0) begin n_fail++; $display("FAIL cfgbeat_match got %b exp 0", match); end
        n_tests++;
        if (armed !== 1'b0) begin n_fail++; $display("FAIL cfgbeat_armed got %b exp 0", armed); end
        for (int i = 4; i >= 0; i--) begin
            beat(full[i]);
            n_tests++;
            if (match !== (i == 0)) begin
                n_fail++; $display("FAIL refill_match beat %0d got %b exp %b", 5 - i, match, i == 0);
            end
        end
        n_tests++;
        if (match_cnt !== 8'd1) begin
            n_fail++; $display("FAIL refill_cnt got %0d exp 1", match_cnt);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_bubbles();
        test_lengths();
        test_saturate();
        test_interrupt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial bit-pattern detector. It is the next generation of the fixed 5-bit sequence checker.
- Pattern, active length and overlap mode are run-time configurable.
- Input is qualified by a valid strobe, so bubbles do not break a sequence.
- Produces a one-cycle match pulse plus a saturating match counter.
- Sits on a serial data path feeding status/interrupt logic.

Parameters:
PAT_W, 8, maximum pattern length in bits (2..32)
CNT_W, 8, match counter width
RST_PAT, 8'b0001_0010, pattern loaded at reset (low 5 bits = 10010)
RST_LEN, 5, active length loaded at reset (1..PAT_W)
RST_OVL, 1, overlap mode loaded at reset

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
din_valid  in  1  din is a sequence bit this cycle
din  in  1  serial data bit
cfg_we  in  1  load cfg_pat/cfg_len/cfg_ovl this cycle
cfg_pat  in  PAT_W  pattern; cfg_pat[len-1] is the oldest bit, cfg_pat[0] the newest
cfg_len  in  $clog2(PAT_W+1)  active pattern length
cfg_ovl  in  1  1 = overlapping matches allowed, 0 = non-overlapping
clr_cnt  in  1  clear match_cnt and cnt_sat
match  out  1  one-cycle pulse, registered
match_cnt  out  CNT_W  number of matches, saturating
cnt_sat  out  1  sticky; match_cnt has saturated
armed  out  1  history holds at least len valid bits (state ARMED)

Behaviour:
- Reset (one clk edge with rst=1):
  - hist=0, fill=0, state=FILL.
  - pat/len/ovl take RST_PAT/RST_LEN/RST_OVL.
  - match=0, match_cnt=0, cnt_sat=0, armed=0.
  - rst overrides every other input; reset mid-sequence discards partial history.
- History: on a din_valid beat, hist <= {hist[PAT_W-2:0], din} and fill increments, saturating at len. Cycles with din_valid=0 change nothing and match=0.
- State machine:
  - FILL: fill<len; no compare. Moves to ARMED on the beat that makes fill==len. A compare happens on that same beat.
  - ARMED: every valid beat compares the low len bits of the new history with the low len bits of pat.
  - On a hit with ovl=1: stay ARMED.
  - On a hit with ovl=0: go to FILL with fill=0, so the next match needs len fresh beats.
- Latency: match=1 in the cycle after the completing din_valid beat, for exactly one cycle. Back-to-back matches are possible when len=1 or when overlap applies.
- Counter:
  - match_cnt increments on the same edge that sets match.
  - At all-ones it holds, and cnt_sat sets and stays set.
  - clr_cnt zeroes both. If clr_cnt and a hit coincide, the clear wins (count=0), but the match pulse is still issued.
- Configuration:
  - cfg_we loads pat/len/ovl, clears hist and fill, and forces FILL.
  - A din beat in the same cycle is ignored.
  - match_cnt is unaffected.
  - cfg_len=0 is loaded as 1; cfg_len>PAT_W is loaded as PAT_W.
- rst > cfg_we > din_valid priority on simultaneous events.
- armed = (state==ARMED), registered.

Decomposition:
- Package seq_detect_pkg holds:
  - state enum {FILL, ARMED}
  - default pattern, length and overlap constants
  - a length-clamp function
  - a compare-mask function giving the low len bits set
- One natural sub-module, sat_counter (params W), with ports clk, rst, clr, inc, cnt, sat. It is reusable elsewhere in the codebase.

Test Plan:
- Reset defaults (10010, len 5, ovl 1); valid stream 1,0,0,1,0,0,1,0 -> match after beats 5 and 8; match_cnt=2.
- Same stream after cfg_we with cfg_ovl=0, pat 10010, len 5 -> single match after beat 5; match_cnt=1; armed drops to 0 for 5 beats after the hit.
- Same stream with din_valid=0 bubbles of 1-3 cycles inserted between beats -> identical match beats; match pulses exactly 1 cycle after each completing beat.
- cfg_len=3, cfg_pat=3'b101, ovl=1; stream 1,0,1,0,1 -> matches after beats 3 and 5. Then cfg_len=0 with pat bit0=1, stream 1,1 -> two back-to-back pulses.
- CNT_W=2, 5 matches -> match_cnt=3, cnt_sat=1. Then clr_cnt coinciding with a hit -> match=1, match_cnt=0, cnt_sat=0.
- Feed 1,0,0,1, then rst for 1 cycle, then 0 -> no match; armed=0; match_cnt=0. A cfg_we coinciding with the last beat of a sequence -> no match.
